// File: rtl/fetch_decode_queue_if.sv
// Fetch/decode handshake bundle for fetch_decode_queue: fetch-side push, decode-side head and occupancy.
interface fetch_decode_queue_if #(
    parameter int unsigned PTR_W = 2
);
    logic             inValid;
    logic             inReady;
    logic [31:0]      inPC;
    logic [31:0]      inInstr;
    logic             outValid;
    logic             outReady;
    logic [31:0]      outPC;
    logic [31:0]      outPCPlus4;
    logic [31:0]      outInstr;
    logic [PTR_W:0]   count;

    modport master (
        output inValid, inPC, inInstr, outReady,
        input  inReady, outValid, outPC, outPCPlus4, outInstr, count
    );

    modport slave (
        input  inValid, inPC, inInstr, outReady,
        output inReady, outValid, outPC, outPCPlus4, outInstr, count
    );
endinterface

// File: rtl/fetch_decode_queue.sv
// Circular instruction FIFO between fetch and decode with branch flush.
// Optional FDQ_STALL_COUNT_EN adds a saturating decode-stall counter on stallCount.
module fetch_decode_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    fetch_decode_queue_if.slave bus
`ifdef FDQ_STALL_COUNT_EN
    ,
    output logic [31:0]         stallCount
`endif
);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      pcMem    [DEPTH];
    logic [31:0]      instrMem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] cnt;
    logic             notEmpty;
    logic             notFull;
    logic             push;
    logic             pop;

    assign notEmpty = (cnt != '0);
    assign notFull  = (cnt != CNT_W'(DEPTH));
    assign push     = bus.inValid & notFull;
    assign pop      = notEmpty & bus.outReady;

    // Pointers and occupancy; count disambiguates wptr == rptr
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is never reset; contents are only observed through the count
    always_ff @(posedge clk) begin
        if (reset && !flush && push) begin
            pcMem[wptr]    <= bus.inPC;
            instrMem[wptr] <= bus.inInstr;
        end
    end

    // Empty queue presents all-zero head (MIPS nop)
    always_comb begin
        bus.inReady    = notFull;
        bus.outValid   = notEmpty;
        bus.count      = cnt;
        bus.outPC      = '0;
        bus.outPCPlus4 = '0;
        bus.outInstr   = '0;
        if (notEmpty) begin
            bus.outPC      = pcMem[rptr];
            bus.outPCPlus4 = pcMem[rptr] + 32'd4;
            bus.outInstr   = instrMem[rptr];
        end
    end

`ifdef FDQ_STALL_COUNT_EN
    // Cycles with a head waiting on decode; survives flush, saturates
    always_ff @(posedge clk) begin
        if (!reset) begin
            stallCount <= '0;
        end else if (notEmpty && !bus.outReady && (stallCount != 32'hFFFF_FFFF)) begin
            stallCount <= stallCount + 32'd1;
        end
    end
`endif
endmodule
